bcd_display_scanner: RTL

Time-multiplexed 4-digit 7-segment driver that consumes the four BCD digit outputs of the skill-test calculator (BCD3..BCD0, with all-1111 meaning overflow) and drives a common-anode display. Inputs are snapshotted once per frame so a digit never changes mid-frame. Leading zeros are suppressed, and overflow is shown as four blinking dashes. It sits between the calculator core and the board pins.

---
 rtl/display_pkg.sv | 58 +++++
 rtl/seg7_decode.sv | 34 +++
 rtl/bcd_display_scanner.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants for the BCD display scanner: digit-slot states,
// the calculator overflow code and active-low 7-segment patterns.
package display_pkg;

  // Digit slot currently being driven; wraps S_D3 -> S_D0 once per frame.
  typedef enum logic [1:0] {
    S_D0 = 2'd0,
    S_D1 = 2'd1,
    S_D2 = 2'd2,
    S_D3 = 2'd3
  } digit_state_e;

  // Calculator signals overflow by driving every BCD digit to this code.
  localparam logic [3:0] OVF_CODE = 4'hF;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Successor slot in the scan order.
  function automatic digit_state_e next_digit(input digit_state_e s);
    digit_state_e n;
    n = S_D0;
    case (s)
      S_D0:    n = S_D1;
      S_D1:    n = S_D2;
      S_D2:    n = S_D3;
      S_D3:    n = S_D0;
      default: n = S_D0;
    endcase
    return n;
  endfunction

  // Active-low anode enable for a slot (dead time handled by the caller).
  function automatic logic [3:0] slot_anode(input digit_state_e s);
    logic [3:0] a;
    a = '1;
    case (s)
      S_D0:    a = 4'b1110;
      S_D1:    a = 4'b1101;
      S_D2:    a = 4'b1011;
      S_D3:    a = 4'b0111;
      default: a = '1;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder with dash and blank
// overrides. Dash wins over blank; non-decimal values show blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  // Select the pattern: dash override, then blank, then the digit table.
  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i) begin
      case (value_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for the
// calculator's BCD outputs. Inputs are snapshotted at each frame wrap,
// leading zeros are suppressed and overflow blinks four dashes.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [3:0] Anode,
  output logic [6:0] Segments,
  output logic       FrameStart
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  digit_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             fs_q, fs_d;

  logic             ovf;
  logic [3:0]       lz;
  logic [3:0]       cur_digit;
  logic             cur_lz;
  logic             cur_blank;
  logic             cur_dash;
  logic [6:0]       dec_seg;

  // Divide counter and digit FSM; a wrap is the S_D3 -> S_D0 advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    wrap_d  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = next_digit(state_q);
      wrap_d  = (state_q == S_D3);
    end
  end

  // Shadow registers only load on the wrap so a frame never tears.
  always_comb begin
    shadow_d = shadow_q;
    if (wrap_d) begin
      shadow_d = {BCD3, BCD2, BCD1, BCD0};
    end
  end

  assign ovf = (shadow_q == {4{OVF_CODE}});

  // Blink timing advances once per overflow frame; it is held cleared
  // whenever the displayed snapshot is not an overflow, so a fresh
  // overflow always opens with dashes.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!ovf) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (wrap_d) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Leading-zero chain from the most significant digit; digit 0 always shows.
  always_comb begin
    lz    = '0;
    lz[3] = (shadow_q[3] == 4'd0);
    lz[2] = lz[3] && (shadow_q[2] == 4'd0);
    lz[1] = lz[2] && (shadow_q[1] == 4'd0);
    lz[0] = 1'b0;
  end

  // Pick the shadow digit and its suppression flag for the current slot.
  always_comb begin
    cur_digit = shadow_q[0];
    cur_lz    = lz[0];
    case (state_q)
      S_D0: begin cur_digit = shadow_q[0]; cur_lz = lz[0]; end
      S_D1: begin cur_digit = shadow_q[1]; cur_lz = lz[1]; end
      S_D2: begin cur_digit = shadow_q[2]; cur_lz = lz[2]; end
      S_D3: begin cur_digit = shadow_q[3]; cur_lz = lz[3]; end
      default: begin cur_digit = shadow_q[0]; cur_lz = 1'b0; end
    endcase
  end

  assign cur_dash  = ovf && !blink_ph_q;
  assign cur_blank = ovf ? blink_ph_q : cur_lz;

  seg7_decode u_seg7_decode (
    .value_i (cur_digit),
    .blank_i (cur_blank),
    .dash_i  (cur_dash),
    .seg_o   (dec_seg)
  );

  // Output register inputs from the present slot state: anode dead time on
  // counter 0, FrameStart on the first cycle after a wrap.
  always_comb begin
    anode_d = slot_anode(state_q);
    if (cnt_q == '0) begin
      anode_d = '1;
    end
    seg_d = dec_seg;
    fs_d  = wrap_q;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_D0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      shadow_q    <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      anode_q     <= '1;
      seg_q       <= '1;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      shadow_q    <= shadow_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
    end
  end

  assign Anode      = anode_q;
  assign Segments   = seg_q;
  assign FrameStart = fs_q;

endmodule
